// File: rtl/fan_tach_pkg.sv
// Shared fan tach constants and field helper, also used by the Fan LED path
// and the register decode.
package fan_tach_pkg;

    localparam int FAN_NUM_FANS       = 4;
    localparam int FAN_CNT_W          = 8;
    localparam int FAN_WINDOW_STROBES = 64;
    localparam int FAN_MIN_PULSES     = 20;
    localparam int FAN_FAIL_WINDOWS   = 3;
    localparam int FAN_SPINUP_WINDOWS = 4;
    localparam int FAN_SYNC_STAGES    = 3;

    // LSB of fan's count field in a flattened TachCount vector.
    function automatic int tachLsb(input int fan, input int cntW);
        return fan * cntW;
    endfunction

endpackage

// File: rtl/fan_tach_channel.sv
// One fan: input synchronizer, rising-edge detect, saturating pulse count,
// bad-window streak and fail flag.
module fan_tach_channel
    import fan_tach_pkg::*;
#(
    parameter int CNT_W        = FAN_CNT_W,
    parameter int MIN_PULSES   = FAN_MIN_PULSES,
    parameter int FAIL_WINDOWS = FAN_FAIL_WINDOWS
) (
    input  logic             SlowClock,
    input  logic             ResetN,
    input  logic             FanTach,
    input  logic             FanEnable,
    input  logic             WindowEnd,
    input  logic             SpinupActive,
    output logic [CNT_W-1:0] TachCount,
    output logic             FanFail
);

    localparam int                  STREAK_W   = $clog2(FAIL_WINDOWS + 1);
    localparam logic [CNT_W-1:0]    CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]    MIN_CNT    = CNT_W'(MIN_PULSES);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(FAIL_WINDOWS);

    logic [FAN_SYNC_STAGES-1:0] syncPipe;
    logic                       tachRise;
    logic [CNT_W-1:0]           pulseCnt;
    logic [CNT_W-1:0]           finalCnt;
    logic [STREAK_W-1:0]        streak;
    logic [STREAK_W-1:0]        streakNext;
    logic                       underSpeed;

    // Two sync flops plus a history flop; no glitch filtering.
    always_ff @(posedge SlowClock or negedge ResetN) begin
        if (!ResetN) syncPipe <= '0;
        else         syncPipe <= {syncPipe[FAN_SYNC_STAGES-2:0], FanTach};
    end

    assign tachRise = syncPipe[FAN_SYNC_STAGES-2] & ~syncPipe[FAN_SYNC_STAGES-1];

    // An edge landing in the WindowEnd cycle belongs to the closing window.
    always_comb begin
        finalCnt = pulseCnt;
        if (tachRise && (pulseCnt != CNT_MAX)) finalCnt = pulseCnt + CNT_W'(1);
    end

    assign underSpeed = (finalCnt < MIN_CNT);
    assign streakNext = (streak == STREAK_MAX) ? STREAK_MAX : streak + STREAK_W'(1);

    always_ff @(posedge SlowClock or negedge ResetN) begin
        if (!ResetN) begin
            pulseCnt  <= '0;
            TachCount <= '0;
        end else if (WindowEnd) begin
            pulseCnt  <= '0;
            TachCount <= finalCnt;
        end else begin
            pulseCnt  <= finalCnt;
        end
    end

    // Fail is only ever set with the streak saturated, so a saturated
    // under-speed window keeps an existing fail asserted.
    always_ff @(posedge SlowClock or negedge ResetN) begin
        if (!ResetN) begin
            streak  <= '0;
            FanFail <= 1'b0;
        end else if (!FanEnable) begin
            streak  <= '0;
            FanFail <= 1'b0;
        end else if (WindowEnd) begin
            if (underSpeed) begin
                streak  <= streakNext;
                FanFail <= (streakNext == STREAK_MAX) && !SpinupActive;
            end else begin
                streak  <= '0;
                FanFail <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fan_tach_monitor.sv
// Per-fan tach rate monitor: window timing, spin-up blanking, count readback
// and the aggregated Beep to the Fan LED block.
module fan_tach_monitor
    import fan_tach_pkg::*;
#(
    parameter int NUM_FANS       = FAN_NUM_FANS,
    parameter int CNT_W          = FAN_CNT_W,
    parameter int WINDOW_STROBES = FAN_WINDOW_STROBES,
    parameter int MIN_PULSES     = FAN_MIN_PULSES,
    parameter int FAIL_WINDOWS   = FAN_FAIL_WINDOWS,
    parameter int SPINUP_WINDOWS = FAN_SPINUP_WINDOWS
) (
    input  logic                      SlowClock,
    input  logic                      ResetN,
    input  logic                      Strobe16ms,
    input  logic [NUM_FANS-1:0]       FanTach,
    input  logic [NUM_FANS-1:0]       FanEnable,
    output logic [NUM_FANS*CNT_W-1:0] TachCount,
    output logic                      CountValid,
    output logic [NUM_FANS-1:0]       FanFailVec,
    output logic                      Beep
);

    localparam int                WIN_W     = (WINDOW_STROBES > 1) ? $clog2(WINDOW_STROBES) : 1;
    localparam int                SPIN_W    = (SPINUP_WINDOWS > 0) ? $clog2(SPINUP_WINDOWS + 1) : 1;
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_STROBES - 1);
    localparam logic [SPIN_W-1:0] SPIN_INIT = SPIN_W'(SPINUP_WINDOWS);

    logic [WIN_W-1:0]  windowCnt;
    logic [SPIN_W-1:0] spinupCnt;
    logic              windowEnd;
    logic              spinupActive;

    assign windowEnd    = Strobe16ms && (windowCnt == WIN_LAST);
    assign spinupActive = (spinupCnt != '0);

    always_ff @(posedge SlowClock or negedge ResetN) begin
        if (!ResetN)         windowCnt <= '0;
        else if (windowEnd)  windowCnt <= '0;
        else if (Strobe16ms) windowCnt <= windowCnt + WIN_W'(1);
    end

    // Spin-up is sampled before its decrement, so the WindowEnd that takes it
    // to zero is still blanked.
    always_ff @(posedge SlowClock or negedge ResetN) begin
        if (!ResetN)                        spinupCnt <= SPIN_INIT;
        else if (windowEnd && spinupActive) spinupCnt <= spinupCnt - SPIN_W'(1);
    end

    always_ff @(posedge SlowClock or negedge ResetN) begin
        if (!ResetN) begin
            CountValid <= 1'b0;
            Beep       <= 1'b0;
        end else begin
            CountValid <= windowEnd;
            Beep       <= |FanFailVec;
        end
    end

    for (genvar g = 0; g < NUM_FANS; g++) begin : gChan
        fan_tach_channel #(
            .CNT_W        (CNT_W),
            .MIN_PULSES   (MIN_PULSES),
            .FAIL_WINDOWS (FAIL_WINDOWS)
        ) uChan (
            .SlowClock    (SlowClock),
            .ResetN       (ResetN),
            .FanTach      (FanTach[g]),
            .FanEnable    (FanEnable[g]),
            .WindowEnd    (windowEnd),
            .SpinupActive (spinupActive),
            .TachCount    (TachCount[tachLsb(g, CNT_W) +: CNT_W]),
            .FanFail      (FanFailVec[g])
        );
    end

endmodule

// File: tb/tb_fan_tach_monitor.sv
// Scoreboard bench for fan_tach_monitor; strobes are compressed to one every
// 8 clocks so a 64-strobe window is 512 clocks.
module tb_fan_tach_monitor;

    localparam int NF  = 4;
    localparam int CW  = 8;
    localparam int GAP = 8;
    localparam int WS  = 64;

    logic             SlowClock = 1'b0;
    logic             ResetN;
    logic             Strobe16ms;
    logic [NF-1:0]    FanTach;
    logic [NF-1:0]    FanEnable;
    logic [NF*CW-1:0] TachCount;
    logic             CountValid;
    logic [NF-1:0]    FanFailVec;
    logic             Beep;

    fan_tach_monitor dut (
        .SlowClock  (SlowClock),
        .ResetN     (ResetN),
        .Strobe16ms (Strobe16ms),
        .FanTach    (FanTach),
        .FanEnable  (FanEnable),
        .TachCount  (TachCount),
        .CountValid (CountValid),
        .FanFailVec (FanFailVec),
        .Beep       (Beep)
    );

    always #5 SlowClock = ~SlowClock;

    typedef struct {
        logic [NF*CW-1:0] tach;
        logic [NF-1:0]    fail;
    } exp_t;

    int      errors = 0;
    int      checks = 0;
    exp_t    sb[$];
    logic    beepPend = 1'b0;
    logic    beepExp  = 1'b0;

    // Stimulus state: mode 0 static low, 1 periodic, 2 K pulses/window,
    // 3 single pulse at window position coPos.
    int       gcyc;
    int       mode[NF];
    int       per[NF];
    int       kPul[NF];
    int       coPos[NF];
    logic [NF-1:0] en = '1;

    // Reference model state
    logic [NF-1:0] m0, m1, m2;
    int            mCnt[NF];
    int            mStreak[NF];
    logic [NF-1:0] mFail;
    int            mSpin, mWin, winEnds;

    function automatic logic fanLevel(input int i);
        int pos;
        pos = mWin * GAP + (gcyc % GAP);
        case (mode[i])
            1:       return (gcyc % per[i]) < (per[i] / 2);
            2:       return ((pos % 16 == 4) || (pos % 16 == 5)) && (pos / 16 < kPul[i]);
            3:       return (pos == coPos[i]) || (pos == coPos[i] + 1);
            default: return 1'b0;
        endcase
    endfunction

    function automatic void resetModel();
        m0 = '0; m1 = '0; m2 = '0; mFail = '0;
        for (int i = 0; i < NF; i++) begin
            mCnt[i] = 0;
            mStreak[i] = 0;
        end
        mSpin = 4; mWin = 0; gcyc = 0;
        sb.delete();
        beepPend = 1'b0;
    endfunction

    function automatic void modelEdge(input logic strobe);
        logic we, rise;
        int   c;
        exp_t e;
        e.tach = '0;
        we = strobe && (mWin == WS - 1);
        for (int i = 0; i < NF; i++) begin
            rise = m1[i] & ~m2[i];
            c = mCnt[i];
            if (rise && c < 255) c++;
            e.tach[i*CW +: CW] = c[CW-1:0];
            mCnt[i] = we ? 0 : c;
            if (!en[i]) begin
                mStreak[i] = 0;
                mFail[i] = 1'b0;
            end else if (we) begin
                if (c < 20) begin
                    if (mStreak[i] < 3) mStreak[i]++;
                    if (mStreak[i] == 3 && mSpin == 0) mFail[i] = 1'b1;
                end else begin
                    mStreak[i] = 0;
                    mFail[i] = 1'b0;
                end
            end
        end
        m2 = m1; m1 = m0; m0 = FanTach;
        if (we) begin
            e.fail = mFail;
            sb.push_back(e);
            if (mSpin > 0) mSpin--;
            mWin = 0;
            winEnds++;
        end else if (strobe) begin
            mWin++;
        end
    endfunction

    task automatic step();
        logic strobe;
        @(negedge SlowClock);
        strobe = (gcyc % GAP) == GAP - 1;
        for (int i = 0; i < NF; i++) FanTach[i] = fanLevel(i);
        Strobe16ms = strobe;
        FanEnable  = en;
        ResetN     = 1'b1;
        @(posedge SlowClock);
        modelEdge(strobe);
        gcyc++;
    endtask

    task automatic runWindows(input int n);
        int target, guard;
        target = winEnds + n;
        guard = 0;
        while (winEnds < target && guard < n * 600) begin
            step();
            guard++;
        end
        if (winEnds < target) begin
            checks++; errors++;
            $display("FAIL window_timeout: got %0d window ends, want %0d", winEnds, target);
        end
    endtask

    task automatic setAll(input int md, input int p);
        for (int i = 0; i < NF; i++) begin
            mode[i] = md;
            per[i] = p;
        end
    endtask

    // Scoreboard consumer: one expected entry per CountValid pulse.
    always @(posedge SlowClock) begin : mon
        exp_t e;
        #1;
        if (beepPend) begin
            checks++;
            if (Beep !== beepExp) begin
                errors++;
                $display("FAIL sb_beep: got %b want %b", Beep, beepExp);
            end
            beepPend = 1'b0;
        end
        if (ResetN === 1'b1 && CountValid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_extra_countvalid: got CountValid=1 want no pending window");
            end else begin
                e = sb.pop_front();
                if (TachCount !== e.tach) begin
                    errors++;
                    $display("FAIL sb_tachcount: got %h want %h", TachCount, e.tach);
                end
                checks++;
                if (FanFailVec !== e.fail) begin
                    errors++;
                    $display("FAIL sb_failvec: got %b want %b", FanFailVec, e.fail);
                end
                beepPend = 1'b1;
                beepExp  = |e.fail;
            end
        end
    end

    task automatic test_reset();
        ResetN = 1'b0; Strobe16ms = 1'b0; FanTach = '0; FanEnable = '1;
        #3;
        checks++; if (TachCount !== '0) begin errors++; $display("FAIL reset_tach: got %h want 0", TachCount); end
        checks++; if (CountValid !== 1'b0) begin errors++; $display("FAIL reset_cv: got %b want 0", CountValid); end
        checks++; if (FanFailVec !== '0) begin errors++; $display("FAIL reset_fail: got %b want 0", FanFailVec); end
        checks++; if (Beep !== 1'b0) begin errors++; $display("FAIL reset_beep: got %b want 0", Beep); end
        repeat (3) @(posedge SlowClock);
        resetModel();
    endtask

    task automatic test_nominal();
        int f;
        setAll(1, 5);
        runWindows(6);
        #1;
        checks++;
        if (FanFailVec !== '0) begin errors++; $display("FAIL nominal_fail: got %b want 0", FanFailVec); end
        for (int i = 0; i < NF; i++) begin
            f = int'(TachCount[i*CW +: CW]);
            checks++;
            if (f < 100 || f > 105) begin errors++; $display("FAIL nominal_rate%0d: got %0d want 100..105", i, f); end
        end
    endtask

    task automatic test_fan_stop();
        mode[2] = 0;
        runWindows(2);
        #1; checks++;
        if (FanFailVec !== 4'b0000) begin errors++; $display("FAIL stop_early: got %b want 0000", FanFailVec); end
        runWindows(1);
        #1; checks++;
        if (FanFailVec !== 4'b0100) begin errors++; $display("FAIL stop_fail: got %b want 0100", FanFailVec); end
        step();
        #1; checks++;
        if (Beep !== 1'b1) begin errors++; $display("FAIL stop_beep: got %b want 1", Beep); end
        mode[2] = 1;
        runWindows(1);
        #1; checks++;
        if (FanFailVec !== 4'b0000) begin errors++; $display("FAIL stop_recover: got %b want 0000", FanFailVec); end
        step();
        #1; checks++;
        if (Beep !== 1'b0) begin errors++; $display("FAIL stop_beep_clear: got %b want 0", Beep); end
    endtask

    task automatic test_static_spinup();
        @(posedge SlowClock); #2;
        ResetN = 1'b0;
        resetModel();
        setAll(0, 5);
        for (int w = 1; w <= 4; w++) begin
            runWindows(1);
            #1; checks++;
            if (FanFailVec !== 4'b0000) begin errors++; $display("FAIL spinup_w%0d: got %b want 0000", w, FanFailVec); end
        end
        runWindows(1);
        #1; checks++;
        if (FanFailVec !== 4'b1111) begin errors++; $display("FAIL spinup_w5: got %b want 1111", FanFailVec); end
    endtask

    task automatic test_sat_boundary();
        mode[0] = 1; per[0] = 2;
        mode[1] = 2; kPul[1] = 20;
        mode[2] = 2; kPul[2] = 25;
        mode[3] = 1; per[3] = 5;
        runWindows(1);
        #1; checks++;
        if (TachCount[7:0] !== 8'd255) begin errors++; $display("FAIL sat_fan0: got %0d want 255", TachCount[7:0]); end
        checks++;
        if (TachCount[15:8] !== 8'd20) begin errors++; $display("FAIL exact20: got %0d want 20", TachCount[15:8]); end
        kPul[2] = 19;
        runWindows(2);
        #1; checks++;
        if (FanFailVec[2] !== 1'b0) begin errors++; $display("FAIL p19_early: got %b want 0", FanFailVec[2]); end
        runWindows(1);
        #1; checks++;
        if (FanFailVec !== 4'b0100) begin errors++; $display("FAIL p19_fail: got %b want 0100", FanFailVec); end
        checks++;
        if (TachCount[23:16] !== 8'd19) begin errors++; $display("FAIL p19_count: got %0d want 19", TachCount[23:16]); end
        checks++;
        if (TachCount[7:0] !== 8'd255) begin errors++; $display("FAIL sat_nowrap: got %0d want 255", TachCount[7:0]); end
    endtask

    task automatic test_enable();
        setAll(1, 5);
        mode[3] = 0;
        runWindows(3);
        #1; checks++;
        if (FanFailVec !== 4'b1000) begin errors++; $display("FAIL en_fail: got %b want 1000", FanFailVec); end
        repeat (10) step();
        en[3] = 1'b0;
        step();
        #1; checks++;
        if (FanFailVec[3] !== 1'b0) begin errors++; $display("FAIL en_drop: got %b want 0", FanFailVec[3]); end
        repeat (20) step();
        en[3] = 1'b1;
        runWindows(2);
        #1; checks++;
        if (FanFailVec !== 4'b0000) begin errors++; $display("FAIL en_rearm_early: got %b want 0000", FanFailVec); end
        runWindows(1);
        #1; checks++;
        if (FanFailVec !== 4'b1000) begin errors++; $display("FAIL en_rearm_fail: got %b want 1000", FanFailVec); end
    endtask

    task automatic test_coincident();
        setAll(1, 5);
        mode[0] = 0;
        runWindows(1);
        mode[0] = 3; coPos[0] = 509;
        runWindows(1);
        #1; checks++;
        if (TachCount[7:0] !== 8'd1) begin errors++; $display("FAIL coinc_closing: got %0d want 1", TachCount[7:0]); end
        coPos[0] = 510;
        runWindows(1);
        #1; checks++;
        if (TachCount[7:0] !== 8'd0) begin errors++; $display("FAIL coinc_next0: got %0d want 0", TachCount[7:0]); end
        runWindows(1);
        #1; checks++;
        if (TachCount[7:0] !== 8'd1) begin errors++; $display("FAIL coinc_carry: got %0d want 1", TachCount[7:0]); end
    endtask

    task automatic test_reset_mid();
        repeat (100) step();
        #1; checks++;
        if (FanFailVec[0] !== 1'b1) begin errors++; $display("FAIL mid_prefail: got %b want 1", FanFailVec[0]); end
        #1;
        ResetN = 1'b0;
        #1;
        checks++; if (TachCount !== '0) begin errors++; $display("FAIL mid_tach: got %h want 0", TachCount); end
        checks++; if (FanFailVec !== '0) begin errors++; $display("FAIL mid_fail: got %b want 0", FanFailVec); end
        checks++; if (Beep !== 1'b0) begin errors++; $display("FAIL mid_beep: got %b want 0", Beep); end
        checks++; if (CountValid !== 1'b0) begin errors++; $display("FAIL mid_cv: got %b want 0", CountValid); end
        resetModel();
        setAll(1, 5);
        runWindows(1);
        repeat (3) step();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_missing: got %0d pending want 0", sb.size()); end
    endtask

    initial begin
        winEnds = 0;
        for (int i = 0; i < NF; i++) begin
            mode[i] = 0; per[i] = 5; kPul[i] = 0; coPos[i] = 0;
        end
        resetModel();
        test_reset();
        test_nominal();
        test_fan_stop();
        test_static_spinup();
        test_sat_boundary();
        test_enable();
        test_coincident();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
